// File: rtl/fw_loader.sv
// Firmware loader: parses a framed byte stream (sync, 16-bit word count, data, XOR checksum),
// writes little-endian 32-bit words into program memory and holds the CPU in reset meanwhile.
module fw_loader #(
    parameter int unsigned ADDR_BITS      = 13,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wen,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam int unsigned     CntW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]     MaxLen   = 17'(1) << ADDR_BITS;
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
        StCsum
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wbuf_q, wbuf_d;
    logic [7:0]      csum_q, csum_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic        accept;
    logic        timed;
    logic        timeout;
    logic [15:0] len_new;

    assign in_ready = (state_q != StWrite);
    assign accept   = in_valid && in_ready;
    assign len_new  = {in_data, len_q[7:0]};
    // Idle-time supervision applies only while waiting for in-frame bytes.
    assign timed    = (state_q == StLen0) || (state_q == StLen1) ||
                      (state_q == StData) || (state_q == StCsum);
    assign timeout  = timed && !accept && (cnt_q == CntLast);

    // waddr/wdata are only meaningful while wen is high; they mirror the index and word buffer.
    assign wen      = (state_q == StWrite);
    assign waddr    = {{(32 - ADDR_BITS){1'b0}}, idx_q[ADDR_BITS-1:0]};
    assign wdata    = wbuf_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            wbuf_q    <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            wbuf_q    <= wbuf_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Frame parser: next-state, datapath updates and flag updates.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        wbuf_d    = wbuf_q;
        csum_d    = csum_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = '0;

        if (timed && !accept) begin
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d   = StLen0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    csum_d    = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if ({1'b0, len_new} > MaxLen) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (len_new == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        idx_d   = '0;
                        lane_d  = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    unique case (lane_q)
                        2'd0: wbuf_d[7:0]   = in_data;
                        2'd1: wbuf_d[15:8]  = in_data;
                        2'd2: wbuf_d[23:16] = in_data;
                        2'd3: wbuf_d[31:24] = in_data;
                        default: ;
                    endcase
                    csum_d = csum_q ^ in_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d  = idx_q + 16'd1;
                lane_d = '0;
                if ((idx_q + 16'd1) == len_q) begin
                    state_d = StCsum;
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout only fires on a cycle without an accepted byte, so it never races a transition.
        if (timeout) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
    end

endmodule

// File: tb/tb_fw_loader.sv
// Randomized self-checking bench for fw_loader; frames are parsed by a whole-frame reference model.
module tb_fw_loader;

    localparam int unsigned TO       = 40;
    localparam int          MAX_WORD = 8192;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int wen_cnt = 0;
    int done_cnt = 0;

    fw_loader #(
        .ADDR_BITS      (13),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (wen) wen_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one byte with a random lead-in gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int   guard;
        logic rdy;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        forever begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) break;
            guard++;
            if (guard > 4) begin
                chk("in_ready_stuck", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Sends a stream holding one frame (optionally preceded by junk) and checks it against
    // the frame-level interpretation: N words written in order, done iff checksum matches.
    task automatic run_frame(input byte_q_t f);
        int          s, n, d, w0, d0;
        logic [31:0] words[$];
        logic [7:0]  cs;
        logic        good, big;
        s = 0;
        while (s < f.size() && f[s] != 8'hA5) s++;
        n   = int'({f[s+2], f[s+1]});
        big = (n > MAX_WORD);
        cs  = 8'h00;
        words = {};
        if (!big) begin
            for (int i = 0; i < n; i++)
                words.push_back({f[s+6+4*i], f[s+5+4*i], f[s+4+4*i], f[s+3+4*i]});
            for (int k = 0; k < 4 * n; k++) cs ^= f[s+3+k];
        end
        good = !big && (f[s+3+4*n] == cs);
        w0 = wen_cnt;
        d0 = done_cnt;
        for (int j = 0; j < f.size(); j++) begin
            send_byte(f[j]);
            d = j - s - 3;
            if (!big && j >= s + 3 && d < 4 * n && d % 4 == 3) begin
                chk("wen_latency", {31'd0, wen}, 32'd1);
                chk("in_ready_write", {31'd0, in_ready}, 32'd0);
                chk("waddr", waddr, d / 4);
                chk("wdata", wdata, words[d/4]);
            end
        end
        if (big) begin
            chk("err_oversize", {31'd0, err}, 32'd1);
            chk("cpu_rst_oversize", {31'd0, cpu_rst}, 32'd1);
        end else begin
            chk("done_end", {31'd0, done}, {31'd0, good});
            chk("err_end", {31'd0, err}, {31'd0, !good});
            chk("cpu_rst_end", {31'd0, cpu_rst}, {31'd0, !good});
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        #1;
        chk("wen_count", wen_cnt - w0, big ? 0 : n);
        chk("done_count", done_cnt - d0, {31'd0, good});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wen"}, {31'd0, wen}, 32'd0);
        chk({tag, "_waddr"}, waddr, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
    endtask

    initial begin
        byte_q_t f;
        int      w0;
        int      n;
        logic [7:0] cs;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Two-word good frame.
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        run_frame(f);
        // Same frame with a bad checksum.
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(f);
        // Leading junk before sync.
        f = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        run_frame(f);
        chk("deadbeef_kept_ready", {31'd0, in_ready}, 32'd1);
        // Oversized word count.
        f = '{8'hA5, 8'h01, 8'h20};
        run_frame(f);
        // Empty frame.
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(f);

        // Timeout after LEN0.
        send_byte(8'hA5);
        send_byte(8'h01);
        w0 = wen_cnt;
        repeat (TO - 1) @(negedge clk);
        chk("err_before_timeout", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("err_timeout", {31'd0, err}, 32'd1);
        chk("cpu_rst_timeout", {31'd0, cpu_rst}, 32'd1);
        chk("ready_after_timeout", {31'd0, in_ready}, 32'd1);
        #1;
        chk("wen_timeout", wen_cnt - w0, 0);

        // Largest accepted count: no error, first word lands at 0, then reset away.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h20);
        chk("err_max_len", {31'd0, err}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("max_len_wen", {31'd0, wen}, 32'd1);
        chk("max_len_waddr", waddr, 32'd0);
        chk("max_len_wdata", wdata, 32'h04030201);
        pulse_reset();

        // Reset during word 3 of a five-word frame.
        w0 = wen_cnt;
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h00);
        for (int i = 0; i < 14; i++) send_byte(8'($urandom_range(0, 255)));
        chk("partial_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        #1;
        chk("partial_wen_count", wen_cnt - w0, 3);
        @(negedge clk);
        pulse_reset();
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        run_frame(f);

        // Random frames: junk prefix, 0..5 words (data may contain the sync byte), some bad sums.
        for (int it = 0; it < 30; it++) begin
            f = {};
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] j;
                j = 8'($urandom_range(0, 255));
                f.push_back((j == 8'hA5) ? 8'h00 : j);
            end
            n = $urandom_range(0, 5);
            f.push_back(8'hA5);
            f.push_back(8'(n));
            f.push_back(8'h00);
            cs = 8'h00;
            for (int k = 0; k < 4 * n; k++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                cs ^= b;
                f.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
            f.push_back(cs);
            run_frame(f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
